imem_boot_ctrl: RTL and testbench
=================================

# imem_boot_ctrl

Boot-time loader and sequencer for the 64-byte instruction memory. Accepts a program as a byte stream over a valid/ready handshake and writes it byte-by-byte into the memory's write port. It verifies an XOR checksum, then zero-fills the unused tail of the memory. The core is held in reset until a load completes cleanly; the block sits between the host/debug byte source, the instruction memory write port and the core reset.

## Interface
- MEM_BYTES, 64: instruction memory size in bytes.
- ADDR_W, 6: byte address width, clog2(MEM_BYTES).
- LEN_W, 7: width of load_len, clog2(MEM_BYTES)+1.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (low = reset).
- load_start  in  1  single-cycle load request.
- load_len  in  LEN_W  program length in bytes, sampled with load_start; valid range 1..MEM_BYTES.
- s_valid  in  1  stream byte valid.
- s_data  in  8  stream byte; program bytes in address order, then one checksum byte.
- s_ready  out  1  block accepts s_data this cycle.
- mem_we  out  1  instruction memory byte write enable.
- mem_addr  out  ADDR_W  byte write address.
- mem_wdata  out  8  byte write data.
- core_rst_n  out  1  core reset, active-low; high only in RUN.
- busy  out  1  high in LOAD, CHK, FILL.
- load_err  out  1  high in ERR.

## Operation
- States: IDLE, LOAD, CHK, FILL, RUN, ERR. Reset enters IDLE.
- IDLE/RUN/ERR + load_start:
  - load_len in 1..MEM_BYTES: go to LOAD; clear the byte index and the checksum accumulator; latch the length.
  - any other load_len: go to ERR.
- load_start in LOAD/CHK/FILL is ignored.
- LOAD: s_ready=1. Each accepted byte (s_valid&&s_ready):
  - writes mem[index];
  - is XORed into the accumulator;
  - increments the index.
  - After the latched length's worth of bytes, go to CHK.
- CHK: s_ready=1. The accepted byte is compared with the accumulator.
  - Equal: go to FILL, or straight to RUN if length==MEM_BYTES.
  - Not equal: go to ERR. No fill writes.
- FILL: one zero write per cycle at addresses len..MEM_BYTES-1, with no stall. After the write to MEM_BYTES-1, go to RUN.
- RUN: core_rst_n=1. load_start restarts a load, and core_rst_n drops.
- ERR: core_rst_n=0, load_err=1. Memory contents are unspecified.
- Index arithmetic is ADDR_W+1 bits wide; the write address never wraps.

## Timing
- Reset values: s_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_rst_n=0, busy=0, load_err=0.
- All outputs are registered. s_ready, busy, load_err and core_rst_n decode the registered state, so they change in the cycle after the transition edge.
- Write latency: a byte accepted at edge N gives mem_we=1 with its mem_addr and mem_wdata during cycle N..N+1, so the memory captures it at edge N+1. mem_we is high exactly one cycle per accepted byte.
- s_valid gaps stall LOAD/CHK indefinitely with no writes.
- FILL: exactly MEM_BYTES-len consecutive mem_we cycles.
- Total for a clean load of len bytes with no stalls:
  - len+1 accepted cycles;
  - MEM_BYTES-len fill cycles;
  - then core_rst_n rises one cycle after the last fill write (or after the checksum for a full-size load).
- Invalid load_len: ERR is entered at the next edge, and no write ever occurs.
- Reset asserted in any state: all outputs go to their reset values immediately, asynchronously. A partial load is abandoned.

## Structure
- Shared package:
  - state enum (IDLE, LOAD, CHK, FILL, RUN, ERR);
  - MEM_BYTES and ADDR_W constants, also used by the instruction memory.
- Single natural sub-module xor_checksum_8: clear, enable, 8-bit data in, 8-bit accumulator out. The FSM, index counter and write-port registers stay in imem_boot_ctrl.

## Test plan
- Reset low with random inputs -> all outputs 0, s_ready 0; after release, stays IDLE with core_rst_n=0.
- load_len=8, bytes 00 10 02 93 00 10 03 93, checksum 01 -> 8 writes to addr 0..7 with those data, then 56 zero writes to addr 8..63, core_rst_n=1, load_err=0.
- Same load with checksum 02 -> load_err=1, core_rst_n=0, no fill writes, s_ready=0.
- load_len=64 with random s_valid gaps -> 64 writes at contiguous addresses only on accepted beats, no FILL cycles, RUN after a correct checksum. Then load_start in RUN -> core_rst_n=0 the next cycle.
- load_len=0 and load_len=65 -> ERR after one edge, zero mem_we pulses.
- Reset asserted after 3 bytes of a 20-byte load -> outputs reset immediately. A new 4-byte load after release completes normally, with writes from address 0.

Source files
------------

// File: rtl/imem_boot_ctrl_pkg.sv
// Shared constants and types for the instruction-memory boot loader.
// MEM_BYTES/ADDR_W are also consumed by the instruction memory itself.
package imem_boot_ctrl_pkg;

    localparam int MEM_BYTES = 64;
    localparam int ADDR_W    = $clog2(MEM_BYTES);
    localparam int LEN_W     = ADDR_W + 1;

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MEM_BYTES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHK,
        ST_FILL,
        ST_RUN,
        ST_ERR
    } state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        wdata;
    } mem_wr_t;

    function automatic logic len_ok(input logic [LEN_W-1:0] len);
        return (len != '0) && (len <= LEN_MAX);
    endfunction

endpackage

// File: rtl/imem_boot_ctrl_xor_checksum_8.sv
// Running XOR of accepted program bytes; cleared at the start of each load.
module xor_checksum_8 (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear_i,
    input  logic       en_i,
    input  logic [7:0] data_i,
    output logic [7:0] acc_o
);

    logic [7:0] acc_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else if (clear_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_q ^ data_i;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot loader: streams a program into instruction memory, checks an XOR
// checksum, zero-fills the tail and releases the core reset on success.
module imem_boot_ctrl
    import imem_boot_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic [LEN_W-1:0]  load_len,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              core_rst_n,
    output logic              busy,
    output logic              load_err
);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [LEN_W-1:0] len_q, len_d;
    mem_wr_t          wr_q, wr_d;
    logic             s_ready_q, busy_q, load_err_q, core_rst_n_q;

    logic             start_req;
    logic             accept;
    logic [7:0]       csum;

    // Loads may only be (re)started from a quiescent state.
    assign start_req = load_start && (state_q inside {ST_IDLE, ST_RUN, ST_ERR});
    assign accept    = s_valid && s_ready_q;

    xor_checksum_8 u_csum (
        .clk     (clk),
        .reset   (reset),
        .clear_i (start_req),
        .en_i    ((state_q == ST_LOAD) && accept),
        .data_i  (s_data),
        .acc_o   (csum)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        len_d    = len_q;
        wr_d     = '{we: 1'b0, addr: wr_q.addr, wdata: wr_q.wdata};

        unique case (state_q)
            ST_IDLE, ST_RUN, ST_ERR: begin
                if (start_req) begin
                    if (len_ok(load_len)) begin
                        state_d = ST_LOAD;
                        idx_d   = '0;
                        len_d   = load_len;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    wr_d.we    = 1'b1;
                    wr_d.addr  = idx_q[ADDR_W-1:0];
                    wr_d.wdata = s_data;
                    idx_d      = idx_q + LEN_W'(1);
                    if (idx_d == len_q) begin
                        state_d = ST_CHK;
                    end
                end
            end
            ST_CHK: begin
                if (accept) begin
                    if (s_data != csum) begin
                        state_d = ST_ERR;
                    end else if (len_q == LEN_MAX) begin
                        state_d = ST_RUN;
                    end else begin
                        // First fill write issues on the checksum edge so the tail
                        // follows without a bubble.
                        state_d    = ST_FILL;
                        wr_d.we    = 1'b1;
                        wr_d.addr  = len_q[ADDR_W-1:0];
                        wr_d.wdata = 8'h00;
                        idx_d      = len_q + LEN_W'(1);
                    end
                end
            end
            ST_FILL: begin
                if (idx_q == LEN_MAX) begin
                    state_d = ST_RUN;
                end else begin
                    wr_d.we    = 1'b1;
                    wr_d.addr  = idx_q[ADDR_W-1:0];
                    wr_d.wdata = 8'h00;
                    idx_d      = idx_q + LEN_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            len_q        <= '0;
            wr_q         <= '0;
            s_ready_q    <= 1'b0;
            busy_q       <= 1'b0;
            load_err_q   <= 1'b0;
            core_rst_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            len_q        <= len_d;
            wr_q         <= wr_d;
            s_ready_q    <= state_d inside {ST_LOAD, ST_CHK};
            busy_q       <= state_d inside {ST_LOAD, ST_CHK, ST_FILL};
            load_err_q   <= (state_d == ST_ERR);
            core_rst_n_q <= (state_d == ST_RUN);
        end
    end

    assign s_ready    = s_ready_q;
    assign mem_we     = wr_q.we;
    assign mem_addr   = wr_q.addr;
    assign mem_wdata  = wr_q.wdata;
    assign core_rst_n = core_rst_n_q;
    assign busy       = busy_q;
    assign load_err   = load_err_q;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Bench for imem_boot_ctrl: table of loads checked against a write-log model.
module tb_imem_boot_ctrl;
    import imem_boot_ctrl_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              load_start = 1'b0;
    logic [LEN_W-1:0]  load_len = '0;
    logic              s_valid = 1'b0;
    logic [7:0]        s_data = '0;
    logic              s_ready, mem_we, core_rst_n, busy, load_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rise_cyc = -1;
    logic prev_rst = 1'b0;

    typedef struct { int addr; int data; int cyc; } wr_t;
    wr_t wq[$];
    int  acc_cyc[$];

    typedef struct { int len; bit fixed; int delta; int gap; int exp_writes; bit exp_run; } vec_t;
    vec_t vt [9];

    always #5 clk = ~clk;

    imem_boot_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .load_len   (load_len),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .core_rst_n (core_rst_n),
        .busy       (busy),
        .load_err   (load_err)
    );

    // Write-port monitor: one log entry per mem_we cycle, stamped with cycle number.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (mem_we) wq.push_back('{int'(mem_addr), int'(mem_wdata), cyc});
        if (core_rst_n && !prev_rst) rise_cyc = cyc;
        prev_rst = core_rst_n;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_pct, output bit ok);
        int n = 0;
        while (gap_pct > 0 && n < 8 && $urandom_range(99) < gap_pct) begin
            @(negedge clk);
            s_valid = 1'b0;
            n++;
        end
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = b;
        n = 0;
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = s_ready;
        if (ok) begin
            @(posedge clk);
            acc_cyc.push_back(cyc + 1);
        end else begin
            s_valid = 1'b0;
        end
    endtask

    task automatic run_load(input string tag, input int len, input bit fixed, input int delta,
                            input int gap, input int exp_writes, input bit exp_run);
        logic [7:0] fx [0:7];
        logic [7:0] prog[$];
        logic [7:0] x = 8'h00;
        logic [7:0] csum_tx;
        bit ok, all_ok, good;
        int n, bad, ecyc, eaddr, edata;
        bit valid_len;
        fx = '{8'h00, 8'h10, 8'h02, 8'h93, 8'h00, 8'h10, 8'h03, 8'h93};
        valid_len = (len >= 1) && (len <= MEM_BYTES);
        wq.delete();
        acc_cyc.delete();
        rise_cyc = -1;
        for (int i = 0; i < len && i < MEM_BYTES; i++) begin
            prog.push_back(fixed ? fx[i % 8] : 8'($urandom));
            x ^= prog[i];
        end
        csum_tx = x ^ 8'(delta);
        good = (csum_tx == x);

        @(negedge clk);
        load_start = 1'b1;
        load_len   = LEN_W'(len);
        @(negedge clk);
        load_start = 1'b0;
        load_len   = LEN_W'($urandom);
        chk({tag, "_start_core_rst"}, 32'(core_rst_n), 32'd0);

        if (!valid_len) begin
            chk({tag, "_err_next_edge"}, 32'(load_err), 32'd1);
            repeat (4) @(negedge clk);
            #1;
            chk({tag, "_no_writes"}, wq.size(), 32'd0);
            chk({tag, "_err_hold"}, {core_rst_n, busy, s_ready, load_err}, 32'b0001);
            return;
        end

        chk({tag, "_busy"}, 32'(busy), 32'd1);
        all_ok = 1'b1;
        for (int i = 0; i < len; i++) begin
            send_byte(prog[i], gap, ok);
            all_ok &= ok;
        end
        send_byte(csum_tx, gap, ok);
        all_ok &= ok;
        chk({tag, "_stream_accepted"}, 32'(all_ok), 32'd1);
        @(negedge clk);
        s_valid = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        #1;
        chk({tag, "_done"}, 32'(busy), 32'd0);
        chk({tag, "_nwrites"}, wq.size(), exp_writes);

        // Expected log: program bytes at accept+1, then zero tail right after the checksum beat.
        bad = 0;
        for (int i = 0; i < wq.size() && all_ok; i++) begin
            if (i < len) begin
                eaddr = i; edata = prog[i]; ecyc = acc_cyc[i];
            end else begin
                eaddr = i; edata = 0; ecyc = acc_cyc[len] + (i - len);
            end
            if (!good && i >= len) bad++;
            else if (wq[i].addr != eaddr || wq[i].data != edata || wq[i].cyc != ecyc) bad++;
        end
        chk({tag, "_write_log_errs"}, bad, 32'd0);
        chk({tag, "_core_rst_n"}, 32'(core_rst_n), 32'(exp_run));
        chk({tag, "_load_err"}, 32'(load_err), 32'(!exp_run));
        chk({tag, "_s_ready_low"}, 32'(s_ready), 32'd0);
        if (exp_run && all_ok) begin
            if (len < MEM_BYTES && wq.size() > 0)
                chk({tag, "_rise_after_fill"}, rise_cyc, wq[wq.size()-1].cyc + 1);
            else
                chk({tag, "_rise_after_csum"}, rise_cyc, acc_cyc[len]);
        end
    endtask

    initial begin
        bit ok;
        vt[0] = '{8,  1, 0,     0,  64, 1};
        vt[1] = '{8,  1, 3,     0,  8,  0};
        vt[2] = '{64, 0, 0,     40, 64, 1};
        vt[3] = '{1,  0, 0,     0,  64, 1};
        vt[4] = '{0,  0, 0,     0,  0,  0};
        vt[5] = '{65, 0, 0,     0,  0,  0};
        vt[6] = '{63, 0, 0,     25, 64, 1};
        vt[7] = '{64, 0, 1,     0,  64, 0};
        vt[8] = '{17, 0, 8'h80, 30, 17, 0};

        repeat (3) begin
            @(negedge clk);
            load_start = 1'($urandom);
            load_len   = LEN_W'($urandom);
            s_valid    = 1'($urandom);
            s_data     = 8'($urandom);
            #1;
            chk("reset_outputs", {s_ready, mem_we, mem_addr, mem_wdata, core_rst_n, busy, load_err}, 32'd0);
        end
        @(negedge clk);
        load_start = 1'b0;
        s_valid    = 1'b0;
        reset      = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("idle_after_reset", {s_ready, mem_we, core_rst_n, busy, load_err}, 32'd0);

        for (int v = 0; v < 9; v++)
            run_load($sformatf("v%0d_len%0d", v, vt[v].len), vt[v].len, vt[v].fixed,
                     vt[v].delta, vt[v].gap, vt[v].exp_writes, vt[v].exp_run);

        // Abandon a 20-byte load after three bytes with an asynchronous reset.
        @(negedge clk);
        load_start = 1'b1;
        load_len   = LEN_W'(20);
        @(negedge clk);
        load_start = 1'b0;
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 0, ok);
        #1;
        chk("pre_reset_write", 32'(mem_we), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("async_reset", {s_ready, mem_we, mem_addr, mem_wdata, core_rst_n, busy, load_err}, 32'd0);
        s_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        run_load("after_reset_len4", 4, 1'b0, 0, 0, 64, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
